game_stage_ctrl: RTL and testbench
==================================

# game_stage_ctrl

Parametrised top-level game-flow controller for the handwritten sudoku game. It sequences menu, peer connection, pre-game countdown, play and game-over, and supports up to NUM_PEERS linked boards. It adds a connection timeout, link-drop detection, a seconds-based countdown, a win/lose/timeout result code and an optional play time limit. It sits between the mouse/button hit-test logic, the inter-board link and the sudoku board core.

## Interface
- NUM_PEERS, 1: number of remote boards on the link, range 1..8
- CLK_PER_SEC, 100_000_000: clk cycles per second tick
- COUNTDOWN_SEC, 3: pre-game countdown length in seconds, range 0..15
- CONNECT_TIMEOUT_SEC, 5: seconds to wait for any peer in CONNECT, at least 1
- TIME_LIMIT_SEC, 600: play time limit in seconds; used only with GAME_TIMER_EN

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- mouse_left  in  1  button level, 1 = pressed
- on_start_button, on_connect_button, on_return_button  in  1 each  cursor over button
- game_finish  in  1  local board solved
- receive_connect  in  NUM_PEERS  per-peer connect request/level
- receive_start  in  1  start from master
- receive_game_finish  in  NUM_PEERS  per-peer finished
- send_connect, send_start, send_game_finish  out  1 each  link outputs
- sudoku_start  out  1  one-cycle board-init pulse
- status  out  1  0 = MASTER, 1 = SLAVE
- peer_mask  out  NUM_PEERS  peers currently linked
- state  out  3  MENU=0, CONNECT=1, COUNTDOWN=2, GAME=3, OVER=4
- countdown  out  4  seconds remaining in COUNTDOWN, else 0
- result  out  2  0 none, 1 WIN, 2 LOSE, 3 TIMEOUT

## Operation
- Reset: state MENU, status MASTER, every output 0, tick counter 0, click history = released.
- click: asserted in any cycle where mouse_left = 0 and its previous-cycle sample = 1, i.e. on release. Press alone does nothing.
- Tick counter: counts 0..CLK_PER_SEC-1 and asserts tick at CLK_PER_SEC-1. It clears on every state change.
- MENU:
  - peer_mask &= receive_connect every cycle to detect link drop. When it reaches 0, send_connect and status return to 0.
  - click & on_connect_button moves to CONNECT and sets send_connect = 1. status becomes SLAVE if any receive_connect bit is high in that cycle, else MASTER.
  - MASTER with click & on_start_button moves to COUNTDOWN. This works with or without peers.
  - SLAVE with receive_start high moves to COUNTDOWN. Start clicks are ignored in SLAVE.
- CONNECT:
  - send_connect is held at 1 and peer_mask |= receive_connect.
  - When peer_mask is nonzero, return to MENU with send_connect kept at 1.
  - After CONNECT_TIMEOUT_SEC ticks with no peer, or on click & on_return_button, return to MENU with send_connect 0, status MASTER and peer_mask 0.
- COUNTDOWN:
  - countdown loads COUNTDOWN_SEC on entry and decrements on each tick.
  - At value 1 with a tick, or immediately if COUNTDOWN_SEC = 0, move to GAME.
- send_start = 1 throughout COUNTDOWN and GAME when MASTER, else 0.
- GAME:
  - game_finish moves to OVER with result WIN.
  - Otherwise, any bit of receive_game_finish & peer_mask moves to OVER with result LOSE. Unmasked peers are ignored.
  - If both arrive in the same cycle, WIN.
- OVER:
  - send_game_finish = 1 while result = WIN.
  - click & on_return_button moves to MENU and clears result and send_game_finish. peer_mask and status are retained.
- Out-of-range state encoding goes to MENU.

## Timing
- All outputs are registered. Every transition and its output updates take effect on the clk edge following the qualifying input cycle, giving 1-cycle latency.
- sudoku_start is high exactly in the first cycle state = GAME, and never otherwise.
- Link inputs are assumed synchronous to clk; no synchroniser is inside the block.
- Reset asserted mid-operation forces the reset values immediately, regardless of clk.

## Configuration
- GAME_TIMER_EN defined:
  - GAME counts ticks; after TIME_LIMIT_SEC ticks it moves to OVER with result TIMEOUT.
  - game_finish in the same cycle yields WIN; a peer finish in the same cycle yields LOSE.
- GAME_TIMER_EN undefined: no timer logic, result is never 3, and TIME_LIMIT_SEC is ignored.

## Test plan
All scenarios use CLK_PER_SEC=10, COUNTDOWN_SEC=3, CONNECT_TIMEOUT_SEC=2 and NUM_PEERS=2.

- Standalone: reset, then press and release on start → state goes to COUNTDOWN with countdown 3,2,1 at 10-cycle spacing → state GAME 30 cycles after entry, sudoku_start high for 1 cycle, send_start=1 → game_finish → OVER, result=1, send_game_finish=1 → return click → MENU, result=0.
- Connect timeout: connect click with receive_connect=00 → CONNECT with send_connect=1 → after 20 cycles, MENU with send_connect=0 and peer_mask=00.
- Master/slave link:
  - receive_connect=10 rises during CONNECT → next cycle MENU, peer_mask=10, status=0.
  - Separately, a connect click while receive_connect=01 → status=1; start clicks are then ignored; receive_start=1 → COUNTDOWN.
- Lose/tie: in GAME with peer_mask=10:
  - receive_game_finish=01 → stays GAME.
  - receive_game_finish=10 → OVER, result=2.
  - Rerun with game_finish and receive_game_finish=10 in the same cycle → result=1.
- Link drop and reset: in MENU with peer_mask=11, drop receive_connect to 00 → peer_mask=00, send_connect=0. Assert reset mid-COUNTDOWN → immediate MENU, all outputs 0.
- With GAME_TIMER_EN and TIME_LIMIT_SEC=2: idle GAME for 20 cycles → OVER, result=3.

Source files
------------

// File: rtl/game_stage_ctrl_if.sv
// Button, link and status bundle of the game-flow controller.
// master = environment (hit-test, link receivers, bench); slave = game_stage_ctrl.
interface game_stage_ctrl_if #(
   parameter int NUM_PEERS = 1
);
   logic                 mouse_left;
   logic                 on_start_button;
   logic                 on_connect_button;
   logic                 on_return_button;
   logic                 game_finish;
   logic [NUM_PEERS-1:0] receive_connect;
   logic                 receive_start;
   logic [NUM_PEERS-1:0] receive_game_finish;
   logic                 send_connect;
   logic                 send_start;
   logic                 send_game_finish;
   logic                 sudoku_start;
   logic                 status;
   logic [NUM_PEERS-1:0] peer_mask;
   logic [2:0]           state;
   logic [3:0]           countdown;
   logic [1:0]           result;

   modport master (
      output mouse_left, on_start_button, on_connect_button, on_return_button,
             game_finish, receive_connect, receive_start, receive_game_finish,
      input  send_connect, send_start, send_game_finish, sudoku_start,
             status, peer_mask, state, countdown, result
   );

   modport slave (
      input  mouse_left, on_start_button, on_connect_button, on_return_button,
             game_finish, receive_connect, receive_start, receive_game_finish,
      output send_connect, send_start, send_game_finish, sudoku_start,
             status, peer_mask, state, countdown, result
   );
endinterface

// File: rtl/game_stage_ctrl.sv
// Game-flow controller: menu, peer connect, countdown, play, game over.
// Optional play time limit enabled by defining GAME_TIMER_EN.
//
// state     | meaning
// MENU      | idle; track link drops, accept connect/start
// CONNECT   | advertise connect, collect peers until found or timeout
// COUNTDOWN | seconds countdown before play
// GAME      | play; wait for local or peer finish (or time limit)
// OVER      | show result until return click
module game_stage_ctrl #(
   parameter int NUM_PEERS           = 1,
   parameter int CLK_PER_SEC         = 100_000_000,
   parameter int COUNTDOWN_SEC       = 3,
   parameter int CONNECT_TIMEOUT_SEC = 5,
   parameter int TIME_LIMIT_SEC      = 600
) (
   input logic              clk,
   input logic              reset,
   game_stage_ctrl_if.slave bus
);
   localparam int TW      = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   // seconds counter serves both the connect timeout and the play limit
   localparam int SEC_MAX = (CONNECT_TIMEOUT_SEC > TIME_LIMIT_SEC) ? CONNECT_TIMEOUT_SEC
                                                                   : TIME_LIMIT_SEC;
   localparam int SW      = $clog2(SEC_MAX + 1);

   localparam logic [TW-1:0] TICK_LAST = TW'(CLK_PER_SEC - 1);
   localparam logic [SW-1:0] CONN_LAST = SW'(CONNECT_TIMEOUT_SEC - 1);
   localparam logic [3:0]    CD_INIT   = 4'(COUNTDOWN_SEC);
   localparam logic [1:0]    RES_NONE  = 2'd0;
   localparam logic [1:0]    RES_WIN   = 2'd1;
   localparam logic [1:0]    RES_LOSE  = 2'd2;
`ifdef GAME_TIMER_EN
   localparam logic [1:0]    RES_TIME  = 2'd3;
   localparam logic [SW-1:0] TIME_LAST = SW'(TIME_LIMIT_SEC - 1);
`endif

   typedef enum logic [2:0] {
      S_MENU      = 3'd0,
      S_CONNECT   = 3'd1,
      S_COUNTDOWN = 3'd2,
      S_GAME      = 3'd3,
      S_OVER      = 3'd4
   } state_e;

   state_e               state_q, state_d;
   logic                 mouse_q;
   logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
   logic [SW-1:0]        sec_q, sec_d;
   logic [3:0]           countdown_q, countdown_d;
   logic [1:0]           result_q, result_d;
   logic                 status_q, status_d;
   logic                 send_connect_q, send_connect_d;
   logic                 send_start_q, send_start_d;
   logic                 send_game_finish_q, send_game_finish_d;
   logic                 sudoku_start_q, sudoku_start_d;
   logic [NUM_PEERS-1:0] peer_mask_q, peer_mask_d;
   logic                 click, tick, peer_done;

   assign click     = mouse_q & ~bus.mouse_left;
   assign tick      = (tick_cnt_q == TICK_LAST);
   assign peer_done = |(bus.receive_game_finish & peer_mask_q);

   always_comb begin
      state_d            = state_q;
      countdown_d        = countdown_q;
      result_d           = result_q;
      status_d           = status_q;
      send_connect_d     = send_connect_q;
      send_start_d       = send_start_q;
      send_game_finish_d = send_game_finish_q;
      sudoku_start_d     = 1'b0;
      peer_mask_d        = peer_mask_q;
      case (state_q)
         S_MENU: begin
            peer_mask_d = peer_mask_q & bus.receive_connect;
            if (peer_mask_d == '0) begin
               send_connect_d = 1'b0;
               status_d       = 1'b0;
            end
            if (click && bus.on_connect_button) begin
               state_d        = S_CONNECT;
               send_connect_d = 1'b1;
               status_d       = |bus.receive_connect;
            end else if ((!status_q && click && bus.on_start_button) ||
                         (status_q && bus.receive_start)) begin
               state_d      = S_COUNTDOWN;
               countdown_d  = CD_INIT;
               send_start_d = ~status_q;
            end
         end
         S_CONNECT: begin
            send_connect_d = 1'b1;
            peer_mask_d    = peer_mask_q | bus.receive_connect;
            if (peer_mask_d != '0) begin
               state_d = S_MENU;
            end else if ((tick && sec_q == CONN_LAST) ||
                         (click && bus.on_return_button)) begin
               state_d        = S_MENU;
               send_connect_d = 1'b0;
               status_d       = 1'b0;
               peer_mask_d    = '0;
            end
         end
         S_COUNTDOWN: begin
            // zero-length countdown falls straight through to GAME
            if (countdown_q == 4'd0 || (tick && countdown_q == 4'd1)) begin
               state_d        = S_GAME;
               countdown_d    = 4'd0;
               sudoku_start_d = 1'b1;
            end else if (tick) begin
               countdown_d = countdown_q - 4'd1;
            end
         end
         S_GAME: begin
            if (bus.game_finish) begin
               state_d            = S_OVER;
               result_d           = RES_WIN;
               send_game_finish_d = 1'b1;
               send_start_d       = 1'b0;
            end else if (peer_done) begin
               state_d      = S_OVER;
               result_d     = RES_LOSE;
               send_start_d = 1'b0;
`ifdef GAME_TIMER_EN
            end else if (tick && sec_q == TIME_LAST) begin
               state_d      = S_OVER;
               result_d     = RES_TIME;
               send_start_d = 1'b0;
`endif
            end
         end
         S_OVER: begin
            if (click && bus.on_return_button) begin
               state_d            = S_MENU;
               result_d           = RES_NONE;
               send_game_finish_d = 1'b0;
            end
         end
         default: begin
            state_d      = S_MENU;
            send_start_d = 1'b0;
         end
      endcase

      if (state_d != state_q) begin
         tick_cnt_d = '0;
         sec_d      = '0;
      end else begin
         tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
         sec_d      = sec_q + SW'(tick);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q            <= S_MENU;
         mouse_q            <= 1'b0;
         tick_cnt_q         <= '0;
         sec_q              <= '0;
         countdown_q        <= 4'd0;
         result_q           <= RES_NONE;
         status_q           <= 1'b0;
         send_connect_q     <= 1'b0;
         send_start_q       <= 1'b0;
         send_game_finish_q <= 1'b0;
         sudoku_start_q     <= 1'b0;
         peer_mask_q        <= '0;
      end else begin
         state_q            <= state_d;
         mouse_q            <= bus.mouse_left;
         tick_cnt_q         <= tick_cnt_d;
         sec_q              <= sec_d;
         countdown_q        <= countdown_d;
         result_q           <= result_d;
         status_q           <= status_d;
         send_connect_q     <= send_connect_d;
         send_start_q       <= send_start_d;
         send_game_finish_q <= send_game_finish_d;
         sudoku_start_q     <= sudoku_start_d;
         peer_mask_q        <= peer_mask_d;
      end
   end

   assign bus.state            = state_q;
   assign bus.countdown        = countdown_q;
   assign bus.result           = result_q;
   assign bus.status           = status_q;
   assign bus.send_connect     = send_connect_q;
   assign bus.send_start       = send_start_q;
   assign bus.send_game_finish = send_game_finish_q;
   assign bus.sudoku_start     = sudoku_start_q;
   assign bus.peer_mask        = peer_mask_q;
endmodule

// File: tb/tb_game_stage_ctrl.sv
// Scoreboard bench for game_stage_ctrl: every output change must match the next
// queued expectation, both in value and in the cycle it appears.
module tb_game_stage_ctrl;
   localparam logic [2:0] MENU = 3'd0, CONN = 3'd1, CD = 3'd2, GAME = 3'd3, OVER = 3'd4;

   typedef struct {
      int          cyc;
      logic [15:0] vec;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];
   logic [15:0] cur, prev;
   bit          first = 1'b1;

   game_stage_ctrl_if #(.NUM_PEERS(2)) bus ();

   game_stage_ctrl #(
      .NUM_PEERS(2), .CLK_PER_SEC(10), .COUNTDOWN_SEC(3),
      .CONNECT_TIMEOUT_SEC(2), .TIME_LIMIT_SEC(2)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] mk(input logic [2:0] st, input logic [3:0] cd,
                                      input logic [1:0] res, input logic stt,
                                      input logic [1:0] pm, input logic sc, input logic ss,
                                      input logic sgf, input logic sst);
      return {st, cd, res, stt, pm, sc, ss, sgf, sst};
   endfunction

   // monitor: any change of the output bundle consumes one expectation
   always @(negedge clk) begin
      exp_t e;
      cur = {bus.state, bus.countdown, bus.result, bus.status, bus.peer_mask,
             bus.send_connect, bus.send_start, bus.send_game_finish, bus.sudoku_start};
      if (first || cur !== prev) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change cycle %0d: got %h, expected no change", cyc, cur);
         end else begin
            e = sb.pop_front();
            if (e.vec !== cur || e.cyc != cyc) begin
               errors++;
               $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
                        e.name, cur, cyc, e.vec, e.cyc);
            end
         end
         prev  = cur;
         first = 1'b0;
      end
   end

   task automatic expect_at(input int c, input string n, input logic [15:0] v);
      exp_t e;
      e.cyc  = c;
      e.vec  = v;
      e.name = n;
      sb.push_back(e);
   endtask

   task automatic nxt();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) nxt();
   endtask

   // press then release; on return the current cycle is the click cycle
   task automatic press_release();
      bus.mouse_left = 1'b1;
      nxt();
      bus.mouse_left = 1'b0;
   endtask

   task automatic push_countdown(input int t, input logic stt, input logic [1:0] pm,
                                 input logic sc, input logic ss);
      expect_at(t + 1,  "cd_enter",     mk(CD, 4'd3, 2'd0, stt, pm, sc, ss, 1'b0, 1'b0));
      expect_at(t + 11, "cd_2",         mk(CD, 4'd2, 2'd0, stt, pm, sc, ss, 1'b0, 1'b0));
      expect_at(t + 21, "cd_1",         mk(CD, 4'd1, 2'd0, stt, pm, sc, ss, 1'b0, 1'b0));
      expect_at(t + 31, "game_enter",   mk(GAME, 4'd0, 2'd0, stt, pm, sc, ss, 1'b0, 1'b1));
      expect_at(t + 32, "sudoku_start_fall", mk(GAME, 4'd0, 2'd0, stt, pm, sc, ss, 1'b0, 1'b0));
   endtask

   task automatic return_click(input string n, input logic stt, input logic [1:0] pm,
                               input logic sc);
      bus.on_return_button = 1'b1;
      press_release();
      expect_at(cyc + 1, n, mk(MENU, 4'd0, 2'd0, stt, pm, sc, 1'b0, 1'b0, 1'b0));
      nxt();
      bus.on_return_button = 1'b0;
      nxt();
   endtask

   initial begin
      int t;
      bus.mouse_left          = 1'b0;
      bus.on_start_button     = 1'b0;
      bus.on_connect_button   = 1'b0;
      bus.on_return_button    = 1'b0;
      bus.game_finish         = 1'b0;
      bus.receive_connect     = 2'b00;
      bus.receive_start       = 1'b0;
      bus.receive_game_finish = 2'b00;
      expect_at(1, "reset_state", 16'h0000);
      nxt();
      nxt();
      reset = 1'b0;
      nxt();

      // standalone game
      bus.on_start_button = 1'b1;
      press_release();
      t = cyc;
      push_countdown(t, 1'b0, 2'b00, 1'b0, 1'b1);
      nxt();
      bus.on_start_button = 1'b0;
      wait_to(t + 35);
      bus.game_finish = 1'b1;
      expect_at(cyc + 1, "win", mk(OVER, 4'd0, 2'd1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
      nxt();
      bus.game_finish = 1'b0;
      nxt();
      return_click("return_menu", 1'b0, 2'b00, 1'b0);

      // connect timeout
      bus.on_connect_button = 1'b1;
      press_release();
      t = cyc;
      expect_at(t + 1,  "connect_enter",   mk(CONN, 4'd0, 2'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
      expect_at(t + 21, "connect_timeout", mk(MENU, 4'd0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
      nxt();
      bus.on_connect_button = 1'b0;
      wait_to(t + 24);

      // master link: peer 1 appears during CONNECT
      bus.on_connect_button = 1'b1;
      press_release();
      t = cyc;
      expect_at(t + 1, "connect_enter2", mk(CONN, 4'd0, 2'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
      nxt();
      bus.on_connect_button = 1'b0;
      nxt();
      bus.receive_connect = 2'b10;
      expect_at(cyc + 1, "peer_linked", mk(MENU, 4'd0, 2'd0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0));
      nxt();
      nxt();

      // lose: unmasked peer ignored, masked peer ends the game
      bus.on_start_button = 1'b1;
      press_release();
      t = cyc;
      push_countdown(t, 1'b0, 2'b10, 1'b1, 1'b1);
      nxt();
      bus.on_start_button = 1'b0;
      wait_to(t + 33);
      bus.receive_game_finish = 2'b01;
      nxt();
      nxt();
      bus.receive_game_finish = 2'b10;
      expect_at(cyc + 1, "lose", mk(OVER, 4'd0, 2'd2, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0));
      nxt();
      bus.receive_game_finish = 2'b00;
      nxt();
      return_click("return_after_lose", 1'b0, 2'b10, 1'b1);

      // tie resolves to WIN
      bus.on_start_button = 1'b1;
      press_release();
      t = cyc;
      push_countdown(t, 1'b0, 2'b10, 1'b1, 1'b1);
      nxt();
      bus.on_start_button = 1'b0;
      wait_to(t + 34);
      bus.game_finish         = 1'b1;
      bus.receive_game_finish = 2'b10;
      expect_at(cyc + 1, "tie_win", mk(OVER, 4'd0, 2'd1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0));
      nxt();
      bus.game_finish         = 1'b0;
      bus.receive_game_finish = 2'b00;
      nxt();
      return_click("return_after_tie", 1'b0, 2'b10, 1'b1);

      // both peers linked, then link drop
      bus.receive_connect = 2'b11;
      nxt();
      nxt();
      bus.on_connect_button = 1'b1;
      press_release();
      t = cyc;
      expect_at(t + 1, "connect_with_both", mk(CONN, 4'd0, 2'd0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0));
      expect_at(t + 2, "peer_both",         mk(MENU, 4'd0, 2'd0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0));
      nxt();
      bus.on_connect_button = 1'b0;
      wait_to(t + 4);
      bus.receive_connect = 2'b00;
      expect_at(cyc + 1, "link_drop", 16'h0000);
      nxt();
      nxt();

      // slave: start click ignored, receive_start starts countdown
      bus.receive_connect = 2'b01;
      nxt();
      bus.on_connect_button = 1'b1;
      press_release();
      t = cyc;
      expect_at(t + 1, "connect_as_slave", mk(CONN, 4'd0, 2'd0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
      expect_at(t + 2, "slave_linked",     mk(MENU, 4'd0, 2'd0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0));
      nxt();
      bus.on_connect_button = 1'b0;
      wait_to(t + 4);
      bus.on_start_button = 1'b1;
      press_release();
      nxt();
      bus.on_start_button = 1'b0;
      nxt();
      nxt();
      bus.receive_start = 1'b1;
      expect_at(cyc + 1, "slave_countdown", mk(CD, 4'd3, 2'd0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0));
      nxt();
      bus.receive_start = 1'b0;
      repeat (4) nxt();

      // asynchronous reset mid-COUNTDOWN: visible before the next clk edge
      reset = 1'b1;
      expect_at(cyc, "async_reset", 16'h0000);
      nxt();
      nxt();
      reset = 1'b0;
      bus.receive_connect = 2'b00;
      nxt();

`ifdef GAME_TIMER_EN
      bus.on_start_button = 1'b1;
      press_release();
      t = cyc;
      push_countdown(t, 1'b0, 2'b00, 1'b0, 1'b1);
      expect_at(t + 51, "timeout", mk(OVER, 4'd0, 2'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
      nxt();
      bus.on_start_button = 1'b0;
      wait_to(t + 55);
`endif

      repeat (3) nxt();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0 (next %s at cycle %0d)",
                  sb.size(), sb[0].name, sb[0].cyc);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
